// File: rtl/thermal_pkg.sv
// Shared thermal definitions: state encoding and default thresholds, also
// reused by the temperature monitor.
package thermal_pkg;

   typedef enum logic [1:0] {
      ST_COOL = 2'd0,
      ST_WARM = 2'd1,
      ST_HOT  = 2'd2
   } therm_state_e;

   localparam int unsigned DEF_WIDTH    = 10;
   localparam logic [9:0]  DEF_WARN_ON  = 10'd500;
   localparam logic [9:0]  DEF_WARN_OFF = 10'd480;
   localparam logic [9:0]  DEF_CRIT_ON  = 10'd800;
   localparam logic [9:0]  DEF_CRIT_OFF = 10'd760;

endpackage

// File: rtl/fan_pwm_gen.sv
// Free-running PWM generator with a wrap-aligned duty register and a
// force-high override used while the system is hot.
module fan_pwm_gen #(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] i_duty,
   input  logic                i_force,
   output logic                o_pwm
);

   logic [PWM_BITS-1:0] r_pc;
   logic [PWM_BITS-1:0] r_duty;
   logic                r_pwm;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc   <= '0;
         r_duty <= '0;
         r_pwm  <= 1'b0;
      end else begin
         r_pc <= r_pc + 1'b1;
         // Duty only changes as the counter rolls over, so no period is truncated.
         if (r_pc == '1) begin
            r_duty <= i_duty;
         end
         r_pwm <= i_force | (r_pc < r_duty);
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/thermal_fan_ctrl.sv
// Thermal state classifier with hysteresis and debounce, latched critical
// alarm, and PWM fan drive.
module thermal_fan_ctrl
   import thermal_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter logic [WIDTH-1:0] WARN_ON   = DEF_WARN_ON,
   parameter logic [WIDTH-1:0] WARN_OFF  = DEF_WARN_OFF,
   parameter logic [WIDTH-1:0] CRIT_ON   = DEF_CRIT_ON,
   parameter logic [WIDTH-1:0] CRIT_OFF  = DEF_CRIT_OFF,
   parameter int               CONFIRM   = 3,
   parameter int               PWM_BITS  = 8,
   parameter logic [PWM_BITS-1:0] DUTY_WARM = 8'd128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] temp_in,
   input  logic             temp_valid,
   input  logic             alarm_ack,
   output logic [1:0]       state,
   output logic [WIDTH-1:0] temp_last,
   output logic             fan_pwm,
   output logic             overheat_led,
   output logic             alarm
);

   localparam int CNT_W = $clog2(CONFIRM + 1);

   therm_state_e        r_state;
   therm_state_e        r_pend;
   logic [CNT_W-1:0]    r_cnt;
   logic [WIDTH-1:0]    r_temp_last;
   logic                r_led;
   logic                r_alarm;

   therm_state_e        w_target;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic                w_entry_hot;
   logic [PWM_BITS-1:0] w_duty;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_target = ST_COOL;
      if (temp_in >= CRIT_ON) begin
         w_target = ST_HOT;
      end else if (r_state == ST_HOT && temp_in >= CRIT_OFF) begin
         w_target = ST_HOT;
      end else if (temp_in >= WARN_ON) begin
         w_target = ST_WARM;
      end else if (r_state != ST_COOL && temp_in >= WARN_OFF) begin
         w_target = ST_WARM;
      end
   end

   assign w_cnt_inc   = (w_target == r_pend) ? r_cnt + 1'b1 : CNT_W'(1);
   assign w_entry_hot = temp_valid && (w_target == ST_HOT) && (r_state != ST_HOT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_COOL;
         r_pend      <= ST_COOL;
         r_cnt       <= '0;
         r_temp_last <= '0;
         r_led       <= 1'b0;
         r_alarm     <= 1'b0;
      end else begin
         if (temp_valid) begin
            r_temp_last <= temp_in;
            if (w_entry_hot) begin
               // Escalation bypasses the debounce entirely.
               r_state <= ST_HOT;
               r_pend  <= ST_HOT;
               r_cnt   <= '0;
               r_led   <= 1'b1;
            end else if (w_target == r_state) begin
               r_cnt <= '0;
            end else begin
               r_pend <= w_target;
               if (w_cnt_inc == CNT_W'(CONFIRM)) begin
                  r_state <= w_target;
                  r_cnt   <= '0;
                  r_led   <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end
         end
         // Entry outranks a same-cycle ack; an ack while hot is simply dropped.
         if (w_entry_hot) begin
            r_alarm <= 1'b1;
         end else if (alarm_ack && r_state != ST_HOT) begin
            r_alarm <= 1'b0;
         end
      end
   end

   always_comb begin
      w_duty = '0;
      case (r_state)
         ST_WARM: w_duty = DUTY_WARM;
         ST_HOT:  w_duty = '1;
         default: w_duty = '0;
      endcase
   end

   fan_pwm_gen #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk     (clk),
      .rst     (rst),
      .i_duty  (w_duty),
      .i_force (r_state == ST_HOT),
      .o_pwm   (fan_pwm)
   );

   assign state        = r_state;
   assign temp_last    = r_temp_last;
   assign overheat_led = r_led;
   assign alarm        = r_alarm;

endmodule

// File: tb/tb_thermal_fan_ctrl.sv
// Directed self-checking bench for thermal_fan_ctrl with default parameters.
module tb_thermal_fan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] temp_in = '0;
   logic       temp_valid = 1'b0;
   logic       alarm_ack = 1'b0;
   logic [1:0] state;
   logic [9:0] temp_last;
   logic       fan_pwm;
   logic       overheat_led;
   logic       alarm;

   int n_checks = 0;
   int n_errors = 0;
   int fan_cnt;

   always #5 clk = ~clk;

   thermal_fan_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .temp_in      (temp_in),
      .temp_valid   (temp_valid),
      .alarm_ack    (alarm_ack),
      .state        (state),
      .temp_last    (temp_last),
      .fan_pwm      (fan_pwm),
      .overheat_led (overheat_led),
      .alarm        (alarm)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One valid sample across one rising edge; returns at the following negedge.
   task automatic send(input logic [9:0] v);
      @(negedge clk);
      temp_in    = v;
      temp_valid = 1'b1;
      @(negedge clk);
      temp_valid = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      alarm_ack = 1'b1;
      @(negedge clk);
      alarm_ack = 1'b0;
   endtask

   task automatic count_fan(input int n, output int c);
      c = 0;
      repeat (n) begin
         @(negedge clk);
         c += int'(fan_pwm);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_state", state, 0);
      check("rst_temp_last", temp_last, 0);
      check("rst_fan", fan_pwm, 0);
      check("rst_led", overheat_led, 0);
      check("rst_alarm", alarm, 0);

      // Cool samples
      send(10'd100);
      send(10'd100);
      check("cool_state", state, 0);
      check("cool_temp_last", temp_last, 100);
      check("cool_alarm", alarm, 0);
      count_fan(300, fan_cnt);
      check("cool_fan_high_cycles", fan_cnt, 0);

      // Interrupted run does not transition
      send(10'd520); check("int_s1", state, 0);
      send(10'd100); check("int_s2", state, 0);
      send(10'd520); check("int_s3", state, 0);
      send(10'd520); check("warm_s2", state, 0);
      send(10'd520); check("warm_s3", state, 1);
      check("warm_temp_last", temp_last, 520);

      // Warm duty 128/256 once past the first wrap
      count_fan(300, fan_cnt);
      count_fan(512, fan_cnt);
      check("warm_fan_high_cycles", fan_cnt, 256);

      // Escalation to HOT
      send(10'd810);
      check("hot_state", state, 2);
      check("hot_led", overheat_led, 1);
      check("hot_alarm", alarm, 1);
      @(negedge clk);
      check("hot_fan_forced", fan_pwm, 1);
      count_fan(300, fan_cnt);
      check("hot_fan_high_cycles", fan_cnt, 300);
      pulse_ack();
      check("hot_ack_ignored", alarm, 1);

      // Hysteresis keeps HOT
      for (int i = 0; i < 5; i++) begin
         send(10'd770);
         check("hot_hyst", state, 2);
      end
      send(10'd700); check("hot_rel1", state, 2);
      send(10'd700); check("hot_rel2", state, 2);
      send(10'd700); check("hot_rel3", state, 1);
      check("rel_led", overheat_led, 0);
      check("rel_alarm_held", alarm, 1);
      pulse_ack();
      check("ack_clears", alarm, 0);

      // WARM hysteresis and release to COOL
      for (int i = 0; i < 5; i++) begin
         send(10'd490);
         check("warm_hyst", state, 1);
      end
      send(10'd470); check("cool_rel1", state, 1);
      send(10'd470); check("cool_rel2", state, 1);
      send(10'd470); check("cool_rel3", state, 0);
      count_fan(300, fan_cnt);
      count_fan(512, fan_cnt);
      check("cool_again_fan_high_cycles", fan_cnt, 0);

      // HOT entry with simultaneous ack
      @(negedge clk);
      temp_in    = 10'd900;
      temp_valid = 1'b1;
      alarm_ack  = 1'b1;
      @(negedge clk);
      temp_valid = 1'b0;
      alarm_ack  = 1'b0;
      check("entry_ack_state", state, 2);
      check("entry_ack_alarm", alarm, 1);

      // Reset mid-debounce with alarm latched
      send(10'd700);
      send(10'd700);
      check("pre_rst_state", state, 2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_state", state, 0);
      check("mid_rst_temp_last", temp_last, 0);
      check("mid_rst_fan", fan_pwm, 0);
      check("mid_rst_led", overheat_led, 0);
      check("mid_rst_alarm", alarm, 0);
      send(10'd520);
      check("post_rst_no_transition", state, 0);
      check("post_rst_temp_last", temp_last, 520);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/thermal_fan_ctrl.md
# thermal_fan_ctrl

Closed-loop fan and alarm controller driven by the temperature sample stream (`temp_in`/`temp_valid`) that feeds the temperature monitor. It classifies each sample into a thermal state with hysteresis and a consecutive-sample debounce, and drives a PWM fan output from that state. It also latches a critical alarm that firmware must acknowledge. It sits between the sensor front end and the board fan driver, LED and interrupt lines.

## Interface
- `WIDTH`, 10, sample width (unsigned)
- `WARN_ON`, 10'd500, COOL→WARM threshold (≥)
- `WARN_OFF`, 10'd480, WARM→COOL release (<); must be < WARN_ON
- `CRIT_ON`, 10'd800, →HOT threshold (≥)
- `CRIT_OFF`, 10'd760, HOT→WARM release (<); must be < CRIT_ON and ≥ WARN_ON
- `CONFIRM`, 3, consecutive agreeing samples required for a debounced transition (≥1)
- `PWM_BITS`, 8, PWM counter width
- `DUTY_WARM`, 8'd128, WARM duty in counts out of 2^PWM_BITS
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `temp_in`  in  WIDTH  temperature sample
- `temp_valid`  in  1  sample qualifier; one sample per high cycle
- `alarm_ack`  in  1  single-cycle firmware acknowledge
- `state`  out  2  current state: COOL=0, WARM=1, HOT=2
- `temp_last`  out  WIDTH  last accepted sample
- `fan_pwm`  out  1  registered fan PWM
- `overheat_led`  out  1  high while state==HOT
- `alarm`  out  1  latched critical alarm

## Operation
- Only cycles with `temp_valid`=1 update `temp_last`, the state and the debounce counter. Other cycles hold them.
- Target state for sample s, given current state S:
  - s ≥ CRIT_ON → HOT.
  - S==HOT and s ≥ CRIT_OFF → HOT.
  - s ≥ WARN_ON → WARM.
  - S≠COOL and s ≥ WARN_OFF → WARM.
  - Otherwise COOL.
- Escalation to HOT is immediate on one sample ≥ CRIT_ON. There is no debounce.
- All other transitions (COOL→WARM, WARM→COOL, HOT→WARM, HOT→COOL) are debounced:
  - The block keeps `pend` (target) and `cnt`.
  - Sample target == S: cnt←0.
  - Target ≠ S and == pend: cnt increments.
  - Target ≠ S and ≠ pend: pend←target, cnt←1.
  - When the post-update cnt reaches CONFIRM: S←pend and cnt←0.
  - CONFIRM=1 means the first disagreeing sample transitions.
- Alarm:
  - Set on any entry into HOT.
  - Cleared by `alarm_ack` only while S≠HOT. An ack while HOT is ignored and not remembered.
  - If HOT entry and ack occur in the same cycle, entry wins and alarm=1.
- PWM:
  - Free-running PWM_BITS counter `pc`.
  - Duty register loaded when pc wraps to 0: COOL→0, WARM→DUTY_WARM.
  - fan_pwm ← (pc < duty).
  - In HOT, fan_pwm←1 every cycle regardless of duty or pc. On leaving HOT, normal duty resumes at the next wrap.
- Reset values: state=COOL, pend=COOL, cnt=0, temp_last=0, pc=0, duty=0, fan_pwm=0, overheat_led=0, alarm=0.
- Reset mid-operation overrides any pending transition or latched alarm within one cycle.

## Timing
- A sample accepted at edge t produces new `temp_last`, `state`, `overheat_led` and `alarm` visible after edge t (1-cycle latency).
- `fan_pwm` is forced high in the cycle after HOT is visible (2 cycles from the sample).
- A WARM duty change takes effect at the first wrap after the state change, within ≤ 2^PWM_BITS+1 cycles.
- Back-to-back `temp_valid` is supported every cycle.
- Samples need not be contiguous for debounce: only valid samples count, and gaps do not reset cnt.
- `alarm_ack` has effect only on the cycle it is high.

## Structure
- Shared package `thermal_pkg`: state encoding localparams (ST_COOL/ST_WARM/ST_HOT), and the default threshold constants for reuse by the temperature monitor.
- Sub-module `fan_pwm_gen`:
  - Contains the counter, the duty register with wrap-aligned load, and the force-high input.
  - Parameterised by PWM_BITS.
- FSM, debounce and alarm latch stay in the top level.

## Test plan
- Reset, then samples 100,100 → state=COOL, fan_pwm=0 for all cycles, alarm=0, temp_last=100.
- Samples 520,520,520 (CONFIRM=3):
  - → state=WARM after the third sample, not earlier.
  - fan_pwm duty 128/256 from the next wrap.
  - Samples 520,100,520 → no transition.
- From WARM, sample 810:
  - → state=HOT, overheat_led=1 and alarm=1 the next cycle; fan_pwm=1 the cycle after.
  - alarm_ack while HOT → alarm stays 1.
- From HOT:
  - Samples 770×5 → remains HOT (hysteresis).
  - Samples 700×3 → WARM.
  - Then alarm_ack → alarm=0 the next cycle.
- From WARM:
  - 490×5 → stays WARM.
  - 470,470,470 → COOL; duty 0 after the wrap.
  - HOT entry with simultaneous ack → alarm=1.
- Assert rst mid-debounce (cnt=2) with alarm=1 → next cycle all outputs are at reset values. One following sample 520 does not transition.
